// File: rtl/llmint8_quant_pkg.sv
// Shared types and sizing helpers for the streaming int8 block quantizer.
package llmint8_quant_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX,
    S_DIV,
    S_MULT,
    S_OUT
  } state_t;

  function automatic int qmax(input int out_width);
    return (1 << (out_width - 1)) - 1;
  endfunction

  function automatic int recip_width(input int out_width, input int recip_frac_width);
    return out_width - 1 + recip_frac_width;
  endfunction

endpackage

// File: rtl/llmint8_recip_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, NUM_W clocks per division.
module llmint8_recip_divider #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CW = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [NUM_W-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DEN_W:0]   w_shift;
  logic [DEN_W-1:0] w_diff;
  logic             w_ge;

  // Numerator bits shift out of the top of r_quo as quotient bits shift in.
  assign w_shift = {r_rem, r_quo[NUM_W-1]};
  assign w_ge    = w_shift >= {1'b0, r_den};
  assign w_diff  = w_shift[DEN_W-1:0] - r_den;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (start) begin
      r_rem  <= '0;
      r_den  <= denominator;
      r_quo  <= numerator;
      r_cnt  <= CW'(NUM_W);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_rem  <= w_ge ? w_diff : w_shift[DEN_W-1:0];
      r_quo  <= {r_quo[NUM_W-2:0], w_ge};
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_quo;

endmodule

// File: rtl/llmint8_stream_quantizer.sv
// Handshaked int8 block quantizer: absmax, reciprocal scale, round and saturate to int8.
// Optional saturation-count macro adds a saturating count of clamped lanes (sat_count).
//
// state  | meaning
// S_IDLE | ready for a block, capture on valid
// S_MAX  | absmax of captured block, start divider unless zero
// S_DIV  | wait for reciprocal scale
// S_MULT | scale, round, saturate, register outputs
// S_OUT  | hold outputs until downstream accepts
module llmint8_stream_quantizer
  import llmint8_quant_pkg::*;
#(
  parameter int IN_WIDTH         = 16,
  parameter int IN_FRAC_WIDTH    = 8,
  parameter int IN_SIZE          = 4,
  parameter int IN_PARALLELISM   = 1,
  parameter int OUT_WIDTH        = 8,
  parameter int RECIP_FRAC_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  data_in [IN_PARALLELISM*IN_SIZE],
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out [IN_PARALLELISM*IN_SIZE],
  output logic [IN_WIDTH-1:0]         max_num_out,
  output logic                        zero_block,
  output logic                        data_out_valid,
`ifdef LLMINT8_QUANT_SAT_COUNT_EN
  output logic [15:0]                 sat_count,
`endif
  input  logic                        data_out_ready
);

  localparam int N      = IN_PARALLELISM * IN_SIZE;
  localparam int QMAX_L = qmax(OUT_WIDTH);
  localparam int RW     = recip_width(OUT_WIDTH, RECIP_FRAC_WIDTH);
  localparam int PW     = IN_WIDTH + RW + 1;
  localparam logic [RW-1:0]        NUMER  = RW'(QMAX_L) << RECIP_FRAC_WIDTH;
  localparam logic signed [PW-1:0] P_QMAX = PW'(QMAX_L);
  localparam logic signed [PW-1:0] P_HALF = PW'(1) << (RECIP_FRAC_WIDTH - 1);

  // The fraction width cancels in x/absmax, so it only has to be sane.
  if (IN_FRAC_WIDTH < 0 || IN_FRAC_WIDTH >= IN_WIDTH) begin : g_bad_frac
    $error("IN_FRAC_WIDTH out of range");
  end

  state_t r_state, w_next;

  logic signed [IN_WIDTH-1:0]  r_data [N];
  logic [IN_WIDTH-1:0]         w_mag [N];
  logic [IN_WIDTH-1:0]         w_absmax;
  logic [IN_WIDTH-1:0]         r_absmax;
  logic                        r_zero;
  logic                        w_div_start;
  logic                        w_div_busy;
  logic                        w_div_done;
  logic [RW-1:0]               w_quot;
  logic [RW-1:0]               w_recip;
  logic signed [PW-1:0]        w_prod [N];
  logic signed [PW-1:0]        w_q [N];
  logic signed [OUT_WIDTH-1:0] w_sat [N];
  logic [N-1:0]                w_clamp;
  logic signed [OUT_WIDTH-1:0] r_data_out [N];
  logic [IN_WIDTH-1:0]         r_max_out;
  logic                        r_zero_out;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exact when read unsigned.
  always_comb begin
    w_absmax = '0;
    for (int i = 0; i < N; i++) begin
      w_mag[i] = r_data[i];
      if (r_data[i][IN_WIDTH-1]) w_mag[i] = ~w_mag[i] + IN_WIDTH'(1);
      if (w_mag[i] > w_absmax) w_absmax = w_mag[i];
    end
  end

  assign w_div_start = (r_state == S_MAX) && (w_absmax != '0);

  llmint8_recip_divider #(
    .NUM_W (RW),
    .DEN_W (IN_WIDTH)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (w_div_start),
    .numerator   (NUMER),
    .denominator (w_absmax),
    .busy        (w_div_busy),
    .done        (w_div_done),
    .quotient    (w_quot)
  );

  always_comb begin
    w_recip = r_zero ? '0 : w_quot;
    w_clamp = '0;
    for (int i = 0; i < N; i++) begin
      w_prod[i] = PW'(r_data[i]) * PW'($signed({1'b0, w_recip}));
      w_q[i]    = (w_prod[i] + P_HALF) >>> RECIP_FRAC_WIDTH;
      if (w_q[i] > P_QMAX) begin
        w_sat[i]   = OUT_WIDTH'(QMAX_L);
        w_clamp[i] = 1'b1;
      end else if (w_q[i] < -P_QMAX) begin
        w_sat[i]   = OUT_WIDTH'(-QMAX_L);
        w_clamp[i] = 1'b1;
      end else begin
        w_sat[i] = w_q[i][OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (data_in_valid) w_next = S_MAX;
      S_MAX:   w_next = (w_absmax == '0) ? S_MULT : S_DIV;
      S_DIV:   if (w_div_done && !w_div_busy) w_next = S_MULT;
      S_MULT:  w_next = S_OUT;
      S_OUT:   if (data_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_data[i]     <= '0;
        r_data_out[i] <= '0;
      end
      r_absmax   <= '0;
      r_zero     <= 1'b0;
      r_max_out  <= '0;
      r_zero_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_in_valid) begin
            for (int i = 0; i < N; i++) r_data[i] <= data_in[i];
          end
        end
        S_MAX: begin
          r_absmax <= w_absmax;
          r_zero   <= (w_absmax == '0);
        end
        S_MULT: begin
          for (int i = 0; i < N; i++) r_data_out[i] <= w_sat[i];
          r_max_out  <= r_absmax;
          r_zero_out <= r_zero;
        end
        default: ;
      endcase
    end
  end

`ifdef LLMINT8_QUANT_SAT_COUNT_EN
  localparam int CNTW = $clog2(N + 1);

  logic [15:0]   r_sat_count;
  logic [CNTW-1:0] w_nclamp;
  logic [16:0]   w_sum;

  always_comb begin
    w_nclamp = '0;
    for (int i = 0; i < N; i++) w_nclamp = w_nclamp + CNTW'(w_clamp[i]);
    w_sum = {1'b0, r_sat_count} + 17'(w_nclamp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_sat_count <= '0;
    else if (r_state == S_MULT) r_sat_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  assign sat_count = r_sat_count;
`endif

  assign data_in_ready  = (r_state == S_IDLE);
  assign data_out_valid = (r_state == S_OUT);
  assign data_out       = r_data_out;
  assign max_num_out    = r_max_out;
  assign zero_block     = r_zero_out;

endmodule

// File: tb/tb_llmint8_stream_quantizer.sv
// Directed bench for llmint8_stream_quantizer at default parameters, hand-computed vectors.
module tb_llmint8_stream_quantizer;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [15:0] data_in [N];
  logic              data_in_valid;
  logic              data_in_ready;
  logic signed [7:0] data_out [N];
  logic [15:0]       max_num_out;
  logic              zero_block;
  logic              data_out_valid;
  logic              data_out_ready;

  int n_cmp = 0;
  int n_err = 0;

  llmint8_stream_quantizer u_dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .max_num_out    (max_num_out),
    .zero_block     (zero_block),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, data_in_ready, 1);
    chk({tag, "_out_valid"}, data_out_valid, 0);
    chk({tag, "_max"}, max_num_out, 0);
    chk({tag, "_zero"}, zero_block, 0);
    for (int i = 0; i < N; i++) chk($sformatf("%s_out%0d", tag, i), data_out[i], 0);
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    @(negedge clk);
    data_in[0] = 16'(a);
    data_in[1] = 16'(b);
    data_in[2] = 16'(c);
    data_in[3] = 16'(d);
    data_in_valid = 1'b1;
    chk("in_ready_before_accept", data_in_ready, 1);
    @(posedge clk);
    #1 data_in_valid = 1'b0;
  endtask

  // Counts clock edges from the accepting edge to the edge that raises valid.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (data_out_valid) begin
        lat = i;
        break;
      end
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic check_out(input string tag, input int m, input int z,
                           input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_valid"}, data_out_valid, 1);
    chk({tag, "_max"}, max_num_out, m);
    chk({tag, "_zero"}, zero_block, z);
    chk({tag, "_out0"}, data_out[0], e0);
    chk({tag, "_out1"}, data_out[1], e1);
    chk({tag, "_out2"}, data_out[2], e2);
    chk({tag, "_out3"}, data_out[3], e3);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    data_out_ready = 1'b1;
    @(posedge clk);
    #1 data_out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, data_out_valid, 0);
    chk({tag, "_in_ready_back"}, data_in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    for (int i = 0; i < N; i++) data_in[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;

    // recip = floor(127*65536/100) = 83230
    send(100, -50, 25, 0);
    wait_valid("lat_blk1", 26);
    check_out("blk1", 100, 0, 127, -63, 32, 0);
    handshake("blk1");

    // recip = 254; -32768*254 rounds to -127 exactly, never -128
    send(-32768, 0, 0, 0);
    wait_valid("lat_minneg", 26);
    check_out("minneg", 32768, 0, -127, 0, 0, 0);
    handshake("minneg");

    send(0, 0, 0, 0);
    wait_valid("lat_zero", 2);
    check_out("zero", 0, 1, 0, 0, 0, 0);
    handshake("zero");

    // Backpressure with a pending block waiting at the input
    send(100, -50, 25, 0);
    wait_valid("lat_bp", 26);
    data_in[0] = -16'sd32768;
    data_in[1] = '0;
    data_in[2] = '0;
    data_in[3] = '0;
    data_in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", k), data_out_valid, 1);
      chk($sformatf("bp_in_ready_%0d", k), data_in_ready, 0);
      chk($sformatf("bp_out0_%0d", k), data_out[0], 127);
      chk($sformatf("bp_out1_%0d", k), data_out[1], -63);
      chk($sformatf("bp_max_%0d", k), max_num_out, 100);
      chk($sformatf("bp_zero_%0d", k), zero_block, 0);
    end
    data_out_ready = 1'b1;
    @(posedge clk);
    #1 data_out_ready = 1'b0;
    chk("bp_idle_in_ready", data_in_ready, 1);
    chk("bp_idle_valid", data_out_valid, 0);
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    chk("pend_accepted", data_in_ready, 0);
    wait_valid("lat_pend", 26);
    check_out("pend", 32768, 0, -127, 0, 0, 0);
    handshake("pend");

    // Reset during the fifth cycle of the division
    send(100, -50, 25, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset("rst_div");
    @(negedge clk);
    rst = 1'b0;

    // recip = floor(127*65536/20) = 416153
    send(-20, 7, 0, 3);
    wait_valid("lat_after_rst", 26);
    check_out("after_rst", 20, 0, -127, 44, 0, 19);
    handshake("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
